// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver and planned transmitter:
// state encodings, default bit period and frame geometry.
package uart_byte_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_state_t;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
   localparam int unsigned DATA_BITS            = 8;
   localparam int unsigned FRAME_BITS_8N1       = 10;

endpackage : uart_byte_rx_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line does not look like an edge.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver feeding the command handler with single-cycle byte pulses.
// Optional even parity is enabled with the UART_BYTE_RX_PARITY_EN macro.
module uart_byte_rx
   import uart_byte_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk_usb,
   input  logic       rst_n,
   input  logic       rx,
   output logic       byte_ready,
   output logic [7:0] reg_usb_data_in,
   output logic       frame_error,
`ifdef UART_BYTE_RX_PARITY_EN
   output logic       parity_error,
`endif
   output logic       busy
);

   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

   if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_byte_rx: CLKS_PER_BIT must be at least 4");
   end

   logic        rx_s;
   uart_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  shift, shift_n;
   logic [7:0]  data_n;
   logic        ready_n, ferr_n;
   logic        bit_end;
`ifdef UART_BYTE_RX_PARITY_EN
   logic        par, par_n;
   logic        perr_n;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
      .clk   (clk_usb),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

   // State and datapath registers; pulses and busy are registered from next-state
   always_ff @(posedge clk_usb or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         idx             <= '0;
         shift           <= '0;
         reg_usb_data_in <= 8'h00;
         byte_ready      <= 1'b0;
         frame_error     <= 1'b0;
         busy            <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
         par             <= 1'b0;
         parity_error    <= 1'b0;
`endif
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         idx             <= idx_n;
         shift           <= shift_n;
         reg_usb_data_in <= data_n;
         byte_ready      <= ready_n;
         frame_error     <= ferr_n;
         busy            <= (state_n != ST_IDLE);
`ifdef UART_BYTE_RX_PARITY_EN
         par             <= par_n;
         parity_error    <= perr_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shift_n = shift;
      data_n  = reg_usb_data_in;
      ready_n = 1'b0;
      ferr_n  = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
      par_n   = par;
      perr_n  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_n = ST_START;
               cnt_n   = '0;
            end
         end
         // Re-check the line at mid start bit to reject glitches
         ST_START: begin
            if (cnt == CW'(HALF - 1)) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n = ST_DATA;
                  idx_n   = '0;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift[7:1]};
               if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_BYTE_RX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end else begin
                  idx_n = idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
`ifdef UART_BYTE_RX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               cnt_n   = '0;
               par_n   = rx_s;
               state_n = ST_STOP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
`endif
         // Framing error wins over parity; a bad frame never updates the data
         ST_STOP: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
               if (!rx_s) begin
                  ferr_n  = 1'b1;
                  state_n = ST_BREAK;
`ifdef UART_BYTE_RX_PARITY_EN
               end else if ((^shift) != par) begin
                  perr_n  = 1'b1;
`endif
               end else begin
                  ready_n = 1'b1;
                  data_n  = shift;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule : uart_byte_rx

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: stimulus queues expected pulses with
// their arrival cycle, an independent monitor pops them when the DUT pulses.
module tb_uart_byte_rx;

   localparam int unsigned CPB  = 104;
   localparam int unsigned HALF = CPB / 2;
`ifdef UART_BYTE_RX_PARITY_EN
   localparam int unsigned NBITS = 10;
`else
   localparam int unsigned NBITS = 9;
`endif
   localparam int unsigned LAT = 2 + HALF + NBITS * CPB;

   typedef struct {
      int          kind;   // 0 byte, 1 frame error, 2 parity error
      logic [7:0]  data;
      longint      cyc;
   } ev_t;

   logic       clk_usb = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx      = 1'b1;
   logic       byte_ready;
   logic [7:0] reg_usb_data_in;
   logic       frame_error;
   logic       parity_error;
   logic       busy;

   ev_t        expq[$];
   logic [7:0] exp_hold = 8'h00;
   longint     cyc = 0;
   int         tests = 0;
   int         fails = 0;

   uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk_usb         (clk_usb),
      .rst_n           (rst_n),
      .rx              (rx),
      .byte_ready      (byte_ready),
      .reg_usb_data_in (reg_usb_data_in),
      .frame_error     (frame_error),
`ifdef UART_BYTE_RX_PARITY_EN
      .parity_error    (parity_error),
`endif
      .busy            (busy)
   );
`ifndef UART_BYTE_RX_PARITY_EN
   assign parity_error = 1'b0;
`endif

   always #5 clk_usb = ~clk_usb;
   always @(posedge clk_usb) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: every DUT pulse must match the oldest outstanding expectation
   always @(negedge clk_usb) begin
      if (rst_n && (byte_ready || frame_error || parity_error)) begin
         ev_t e;
         int  k;
         k = byte_ready ? 0 : (frame_error ? 1 : 2);
         check("pulse_exclusive", longint'(byte_ready & frame_error), 0);
         if (expq.size() == 0) begin
            check("unexpected_pulse_kind", k, -1);
         end else begin
            e = expq.pop_front();
            check("pulse_kind", k, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            if (e.kind == 0) begin
               check("byte_data", reg_usb_data_in, e.data);
               exp_hold = e.data;
            end else begin
               check("data_held", reg_usb_data_in, exp_hold);
            end
         end
      end
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk_usb);
   endtask

   // Drives one frame starting at a negedge; leaves rx at the stop-bit level
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
      ev_t e;
      e.cyc  = cyc + 1 + LAT;
      e.data = d;
      if (!stop_ok)     e.kind = 1;
      else if (!par_ok) e.kind = 2;
      else              e.kind = 0;
      expq.push_back(e);
      rx = 1'b0;
      repeat (CPB) @(negedge clk_usb);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk_usb);
      end
`ifdef UART_BYTE_RX_PARITY_EN
      rx = (^d) ^ ~par_ok;
      repeat (CPB) @(negedge clk_usb);
`endif
      rx = stop_ok;
      repeat (CPB) @(negedge clk_usb);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (expq.size() != 0 && n < 3 * CPB) begin
         @(negedge clk_usb);
         n++;
      end
      check({name, "_drained"}, expq.size(), 0);
      expq.delete();
   endtask

   initial begin
      repeat (3) @(negedge clk_usb);
      check("rst_byte_ready", byte_ready, 0);
      check("rst_frame_error", frame_error, 0);
      check("rst_busy", busy, 0);
      check("rst_data", reg_usb_data_in, 8'h00);
      rst_n = 1'b1;
      idle(20);

      send_frame(8'hA5, 1, 1);
      idle(40);
      drain("a5");

      send_frame(8'hC0, 1, 1);
      send_frame(8'h02, 1, 1);
      send_frame(8'h00, 1, 1);
      idle(40);
      drain("b2b");

      rx = 1'b0;
      repeat (30) @(negedge clk_usb);
      idle(HALF + 20);
      check("glitch_busy", busy, 0);
      send_frame(8'h3C, 1, 1);
      idle(40);
      drain("glitch");

      send_frame(8'h55, 0, 1);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk_usb);
      idle(40);
      check("break_busy", busy, 0);
      send_frame(8'h3C, 1, 1);
      idle(40);
      drain("ferr");

      // Reset in the middle of data bit 4 of 0xFF; no pulse may follow
      rx = 1'b0;
      repeat (CPB) @(negedge clk_usb);
      rx = 1'b1;
      repeat (4 * CPB + HALF) @(negedge clk_usb);
      rst_n = 1'b0;
      repeat (10) @(negedge clk_usb);
      check("midrst_byte_ready", byte_ready, 0);
      check("midrst_frame_error", frame_error, 0);
      check("midrst_busy", busy, 0);
      check("midrst_data", reg_usb_data_in, 8'h00);
      exp_hold = 8'h00;
      rst_n = 1'b1;
      repeat (6 * CPB) @(negedge clk_usb);
      check("postrst_busy", busy, 0);
      send_frame(8'h81, 1, 1);
      idle(40);
      drain("rst");

`ifdef UART_BYTE_RX_PARITY_EN
      send_frame(8'h07, 1, 0);
      idle(40);
      send_frame(8'h07, 1, 1);
      idle(40);
      drain("parity");
`endif

      // Random traffic with random gaps, bad stop bits and bad parity
      for (int i = 0; i < 10; i++) begin
         logic [7:0] d;
         bit         s_ok, p_ok;
         d    = 8'($urandom);
         s_ok = ($urandom_range(0, 4) != 0);
`ifdef UART_BYTE_RX_PARITY_EN
         p_ok = ($urandom_range(0, 3) != 0);
`else
         p_ok = 1'b1;
`endif
         send_frame(d, s_ok, p_ok);
         idle(s_ok ? int'($urandom_range(0, 200)) : int'($urandom_range(5, 200)));
      end
      idle(40);
      drain("random");
      check("final_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_uart_byte_rx
